channel_select_controller: RTL and testbench
============================================

Name: channel_select_controller

Overview:
- Generates the `select` control consumed by channel_combinator (0 = channel 1 high-gain path, 1 = channel 2 low-gain path).
- Monitors both 11-bit signed channel streams at the 3 MHz sample strobe.
- Switches to channel 2 immediately when channel 1 approaches saturation; returns to channel 1 only after channel 2 has stayed quiet for a hold interval.
- Sits between the two channel front-ends and the combinator, on the same 24 MHz clock.

Parameters:
- DATA_WIDTH, 11, width of signed channel samples.
- UPPER_THRESH, 900, |data_c1| >= this triggers switch to channel 2 (attack).
- LOWER_THRESH, 400, |data_c2| < this counts as a quiet sample (release).
- HOLD_SAMPLES, 64, consecutive quiet samples required before returning to channel 1; legal range 1..4095.

Ports:
- clk  in  1  system clock, 24 MHz
- reset  in  1  asynchronous, active-low reset
- enable_3M  in  1  one-clk-wide sample strobe, one pulse per 8 clks
- data_c1  in  DATA_WIDTH  channel 1 sample, signed two's complement
- data_c2  in  DATA_WIDTH  channel 2 sample, signed two's complement
- select  out  1  registered channel select to the combinator
- select_changed  out  1  one-clk pulse on every select toggle
- hold_count  out  12  current release counter value (debug)
- state_dbg  out  2  encoded FSM state (debug)

Behaviour:
- Reset (reset=0, asynchronous):
  - select=0, select_changed=0, hold_count=0, state=C1_ACTIVE (state_dbg=2'd0).
  - Outputs are held while reset is low. Deassertion takes effect at the next clk edge.
- Sampling:
  - All decisions are made only on clk rising edges where enable_3M=1.
  - With enable_3M=0, state, select and hold_count hold their values and select_changed=0.
- Magnitude:
  - mag = (x<0) ? -x : x, computed at DATA_WIDTH bits treated as unsigned.
  - -1024 maps to 1024. There is no overflow; the comparison is unsigned.
- Latency:
  - select updates on the same edge that samples enable_3M=1, so it is visible 1 clk after the strobe.
  - It stays stable for the full strobe period, and the combinator uses it at the next strobe.
- FSM states:
  - C1_ACTIVE (0): select=0.
    - mag(c1) >= UPPER_THRESH -> C2_ACTIVE; select<=1, select_changed<=1.
  - C2_ACTIVE (1): select=1.
    - mag(c2) < LOWER_THRESH -> RELEASE_WAIT, hold_count<=1.
    - Otherwise stay, hold_count<=0.
  - RELEASE_WAIT (2): select=1.
    - mag(c1) >= UPPER_THRESH -> C2_ACTIVE, hold_count<=0. Re-attack has priority over release.
    - Else mag(c2) >= LOWER_THRESH -> C2_ACTIVE, hold_count<=0.
    - Else if hold_count == HOLD_SAMPLES-1 -> C1_ACTIVE; select<=0, select_changed<=1, hold_count<=0.
    - Else hold_count<=hold_count+1.
  - Encoding 3 is unreachable and recovers to C1_ACTIVE with select=0 on the next strobe.
- Edge cases:
  - HOLD_SAMPLES=1: C2_ACTIVE exits on the first quiet sample directly to C1_ACTIVE. RELEASE_WAIT is skipped, select_changed=1.
  - In C1_ACTIVE, mag(c1) exactly UPPER_THRESH switches (>=). In C2_ACTIVE/RELEASE_WAIT, mag(c2) exactly LOWER_THRESH is not quiet (<).
  - At most one select toggle per strobe.
  - The minimum dwell on channel 2 is HOLD_SAMPLES strobes.
- select_changed is high for exactly the one clk following the toggling edge.
- Reset asserted mid-release: hold_count clears immediately and select drops to 0 asynchronously.

Optional Feature:
- Macro: CHANNEL_SELECT_FORCE_EN.
- Defined:
  - Adds input ports force_en (1) and force_sel (1).
  - While force_en=1, select follows force_sel at each strobe and the FSM holds in C1_ACTIVE (force_sel=0) or C2_ACTIVE (force_sel=1) with hold_count=0.
  - select_changed pulses if the value toggles.
  - Releasing force_en resumes automatic control from that state at the next strobe.
- Undefined: the ports are absent and control is automatic only.

Test Plan:
- Reset with c1=c2=0 for 10 strobes -> select=0, select_changed never asserted, hold_count=0, state_dbg=0.
- c1=899 then c1=900 -> select stays 0 at 899; select=1 one clk after the 900 strobe, select_changed one-clk pulse, state_dbg=1.
- c1=-1024 (full-scale negative) in C1_ACTIVE -> select=1. This checks the magnitude of the most-negative value.
- After switch, c2=100 for 64 strobes -> hold_count counts 1..63; select=0 after the 64th quiet strobe with a select_changed pulse. A c2=400 injected at quiet strobe 30 resets hold_count to 0 and select stays 1.
- In RELEASE_WAIT, a strobe with c1=950 and c2=50 -> state_dbg=1, hold_count=0. Re-attack wins.
- 10 kHz sines, c1 amplitude 1000 and c2 amplitude 114, into the combinator chain -> select=1 within 1 strobe of the first |c1|>=900. With this continuous c2 sine, select returns to 0 only after c2 stays below 400 for 64 consecutive strobes. Assert reset mid-RELEASE_WAIT -> select=0 immediately.

Source files
------------

// File: rtl/channel_select_controller_if.sv
// channel_select_controller_if
//   Groups the sample-side inputs and the select/debug outputs of
//   channel_select_controller.
//   master : channel front-end / supervisor side (drives strobe + samples)
//   slave  : the controller itself
//   Signals:
//     enable_3M      1-clk sample strobe, one pulse per 8 clks
//     data_c1/c2     signed DATA_WIDTH channel samples
//     select         registered channel select (0 = ch1, 1 = ch2)
//     select_changed 1-clk pulse following every select toggle
//     hold_count     release counter (debug)
//     state_dbg      encoded FSM state (debug)
//     force_en/sel   present only with CHANNEL_SELECT_FORCE_EN defined
interface channel_select_controller_if #(
  parameter int DATA_WIDTH = 11
) ();
  logic                  enable_3M;
  logic [DATA_WIDTH-1:0] data_c1;
  logic [DATA_WIDTH-1:0] data_c2;
  logic                  select;
  logic                  select_changed;
  logic [11:0]           hold_count;
  logic [1:0]            state_dbg;
`ifdef CHANNEL_SELECT_FORCE_EN
  logic                  force_en;
  logic                  force_sel;

  modport master (
    output enable_3M, data_c1, data_c2, force_en, force_sel,
    input  select, select_changed, hold_count, state_dbg
  );
  modport slave (
    input  enable_3M, data_c1, data_c2, force_en, force_sel,
    output select, select_changed, hold_count, state_dbg
  );
`else
  modport master (
    output enable_3M, data_c1, data_c2,
    input  select, select_changed, hold_count, state_dbg
  );
  modport slave (
    input  enable_3M, data_c1, data_c2,
    output select, select_changed, hold_count, state_dbg
  );
`endif
endinterface

// File: rtl/channel_select_controller.sv
// channel_select_controller
//   Drives the channel_combinator select: switches to the low-gain channel 2
//   as soon as |data_c1| reaches UPPER_THRESH, and returns to channel 1 only
//   after HOLD_SAMPLES consecutive strobes with |data_c2| < LOWER_THRESH.
//   Decisions happen only on clk edges with enable_3M=1.
//   Ports:
//     clk    24 MHz system clock
//     reset  asynchronous, active-low reset
//     bus    channel_select_controller_if.slave (strobe, samples, select,
//            select_changed, hold_count, state_dbg)
//   Optional: define CHANNEL_SELECT_FORCE_EN to add force_en/force_sel,
//   which override select at each strobe and park the FSM in C1/C2_ACTIVE.
//   The interface DATA_WIDTH must match this module's DATA_WIDTH.
module channel_select_controller #(
  parameter int DATA_WIDTH   = 11,
  parameter int UPPER_THRESH = 900,
  parameter int LOWER_THRESH = 400,
  parameter int HOLD_SAMPLES = 64
) (
  input logic                        clk,
  input logic                        reset,
  channel_select_controller_if.slave bus
);

  typedef enum logic [1:0] {
    C1_ACTIVE    = 2'd0,
    C2_ACTIVE    = 2'd1,
    RELEASE_WAIT = 2'd2
  } state_e;

  localparam logic [DATA_WIDTH-1:0] UPPER_T   = DATA_WIDTH'(UPPER_THRESH);
  localparam logic [DATA_WIDTH-1:0] LOWER_T   = DATA_WIDTH'(LOWER_THRESH);
  localparam logic [11:0]           HOLD_LAST = 12'(HOLD_SAMPLES - 1);

  state_e      state_q, state_d;
  logic        select_q, select_d;
  logic        select_changed_q, select_changed_d;
  logic [11:0] hold_count_q, hold_count_d;

  logic c1_loud;
  logic c2_quiet;

  // Magnitude kept at DATA_WIDTH bits unsigned: the most negative code
  // negates to itself, which read unsigned is exactly its magnitude.
  function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  assign c1_loud  = (mag(bus.data_c1) >= UPPER_T);
  assign c2_quiet = (mag(bus.data_c2) <  LOWER_T);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= C1_ACTIVE;
      select_q         <= 1'b0;
      select_changed_q <= 1'b0;
      hold_count_q     <= '0;
    end else begin
      state_q          <= state_d;
      select_q         <= select_d;
      select_changed_q <= select_changed_d;
      hold_count_q     <= hold_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d          = state_q;
    hold_count_d     = hold_count_q;
    select_d         = select_q;
    select_changed_d = 1'b0;
    if (bus.enable_3M) begin
`ifdef CHANNEL_SELECT_FORCE_EN
      if (bus.force_en) begin
        state_d      = bus.force_sel ? C2_ACTIVE : C1_ACTIVE;
        hold_count_d = '0;
      end else
`endif
      begin
        case (state_q)
          C1_ACTIVE: begin
            hold_count_d = '0;
            if (c1_loud) state_d = C2_ACTIVE;
          end
          C2_ACTIVE: begin
            if (c2_quiet) begin
              // A one-sample hold releases straight from C2_ACTIVE.
              if (HOLD_SAMPLES == 1) begin
                state_d      = C1_ACTIVE;
                hold_count_d = '0;
              end else begin
                state_d      = RELEASE_WAIT;
                hold_count_d = 12'd1;
              end
            end else begin
              hold_count_d = '0;
            end
          end
          RELEASE_WAIT: begin
            if (c1_loud || !c2_quiet) begin
              state_d      = C2_ACTIVE;
              hold_count_d = '0;
            end else if (hold_count_q == HOLD_LAST) begin
              state_d      = C1_ACTIVE;
              hold_count_d = '0;
            end else begin
              hold_count_d = hold_count_q + 12'd1;
            end
          end
          default: begin
            state_d      = C1_ACTIVE;
            hold_count_d = '0;
          end
        endcase
      end
      // select is a pure function of the next state, so it can toggle at
      // most once per strobe and the pulse flags exactly that toggle.
      select_d         = (state_d != C1_ACTIVE);
      select_changed_d = (select_d != select_q);
    end
  end

  // Outputs
  always_comb begin
    bus.select         = select_q;
    bus.select_changed = select_changed_q;
    bus.hold_count     = hold_count_q;
    bus.state_dbg      = state_q;
  end

endmodule

// File: tb/tb_channel_select_controller.sv
// tb_channel_select_controller
//   Scoreboard bench: the driver applies samples on strobes and pushes the
//   expected post-strobe outputs computed from a run-length reference model;
//   a monitor pops and compares one clk after every sampled strobe and checks
//   that select_changed stays low on all other clks.
module tb_channel_select_controller;

  localparam int DW = 11;

  logic clk;
  logic reset;

  channel_select_controller_if #(.DATA_WIDTH(DW)) bus ();

  channel_select_controller #(
    .DATA_WIDTH  (DW),
    .UPPER_THRESH(900),
    .LOWER_THRESH(400),
    .HOLD_SAMPLES(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #21 clk = ~clk;

  typedef struct {
    int sel;
    int chg;
    int hold;
    int st;
    int idx;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_idx = 0;

  // Reference model: on_c2 plus the current run of quiet c2 strobes.
  int m_on_c2 = 0;
  int m_quiet = 0;

  function automatic void check(string name, int idx, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (strobe %0d): got %0d, expected %0d", name, idx, act, exp);
    end
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic exp_t model_step(int c1, int c2);
    exp_t e;
    int   prev;
    prev = m_on_c2;
    if (m_on_c2 == 0) begin
      if (iabs(c1) >= 900) m_on_c2 = 1;
      m_quiet = 0;
    end else if (m_quiet > 0 && iabs(c1) >= 900) begin
      m_quiet = 0;
    end else if (iabs(c2) < 400) begin
      m_quiet++;
      if (m_quiet == 64) begin
        m_on_c2 = 0;
        m_quiet = 0;
      end
    end else begin
      m_quiet = 0;
    end
    e.sel  = m_on_c2;
    e.chg  = (m_on_c2 != prev) ? 1 : 0;
    e.hold = m_on_c2 ? m_quiet : 0;
    e.st   = (m_on_c2 == 0) ? 0 : ((m_quiet == 0) ? 1 : 2);
    e.idx  = strobe_idx;
    return e;
  endfunction

  task automatic strobe(input int c1, input int c2);
    @(negedge clk);
    bus.enable_3M = 1'b1;
    bus.data_c1   = DW'(c1);
    bus.data_c2   = DW'(c2);
    exp_q.push_back(model_step(c1, c2));
    strobe_idx++;
    @(negedge clk);
    bus.enable_3M = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Monitor
  logic en_seen;
  always @(posedge clk or negedge reset) begin
    if (!reset) en_seen <= 1'b0;
    else        en_seen <= bus.enable_3M;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (en_seen) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", strobe_idx, 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("select",         e.idx, int'(bus.select),         e.sel);
          check("select_changed", e.idx, int'(bus.select_changed), e.chg);
          check("hold_count",     e.idx, int'(bus.hold_count),     e.hold);
          check("state_dbg",      e.idx, int'(bus.state_dbg),      e.st);
        end
      end else begin
        check("select_changed_idle", strobe_idx, int'(bus.select_changed), 0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic reset_model();
    m_on_c2 = 0;
    m_quiet = 0;
    exp_q.delete();
  endtask

  initial begin
    int c1, c2, pc1, pc2;
    reset         = 1'b0;
    bus.enable_3M = 1'b0;
    bus.data_c1   = '0;
    bus.data_c2   = '0;
`ifdef CHANNEL_SELECT_FORCE_EN
    bus.force_en  = 1'b0;
    bus.force_sel = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_select",     -1, int'(bus.select),         0);
    check("reset_changed",    -1, int'(bus.select_changed), 0);
    check("reset_hold_count", -1, int'(bus.hold_count),     0);
    check("reset_state_dbg",  -1, int'(bus.state_dbg),      0);
    reset = 1'b1;

    // Idle after reset
    repeat (10) strobe(0, 0);

    // Attack threshold boundary
    strobe(899, 0);
    strobe(900, 0);

    // Release with a non-quiet c2 (exactly 400) at quiet strobe 30
    repeat (29) strobe(0, 100);
    strobe(0, 400);
    repeat (64) strobe(0, 100);
    strobe(0, 0);

    // Most negative sample attacks
    strobe(-1024, 0);
    repeat (5) strobe(0, -399);
    // Re-attack beats release in RELEASE_WAIT
    strobe(950, 50);
    repeat (63) strobe(0, 399);
    strobe(-899, -399);  // 64th quiet strobe: release
    strobe(0, 0);

    // Randomized segments with varying loudness probabilities
    for (int seg = 0; seg < 8; seg++) begin
      pc1 = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 2 : 10);
      pc2 = (seg % 2 == 0) ? 1 : 8;
      for (int k = 0; k < 90; k++) begin
        if (int'($urandom_range(99)) < pc1) c1 = 850 + int'($urandom_range(174));
        else                                 c1 = int'($urandom_range(1798)) - 899;
        if ($urandom_range(1)) c1 = -c1;
        if (int'($urandom_range(99)) < pc2) c2 = 395 + int'($urandom_range(629));
        else                                 c2 = int'($urandom_range(798)) - 399;
        if ($urandom_range(1)) c2 = -c2;
        if (c1 < -1024) c1 = -1024;
        if (c2 < -1024) c2 = -1024;
        strobe(c1, c2);
      end
    end

    // 10 kHz sines at 3 MHz sampling: 300 strobes per period
    for (int k = 0; k < 450; k++) begin
      c1 = $rtoi(1000.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 300.0));
      c2 = $rtoi(114.0  * $sin(2.0 * 3.14159265358979 * real'(k) / 300.0));
      strobe(c1, c2);
    end

    // Get into RELEASE_WAIT, then assert reset asynchronously mid-period
    strobe(1000, 0);
    repeat (10) strobe(0, 0);
    #5;
    reset = 1'b0;
    #1;
    check("async_reset_select",     -1, int'(bus.select),         0);
    check("async_reset_hold_count", -1, int'(bus.hold_count),     0);
    check("async_reset_state_dbg",  -1, int'(bus.state_dbg),      0);
    check("async_reset_changed",    -1, int'(bus.select_changed), 0);
    reset_model();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) strobe(0, 0);
    strobe(-900, 0);
    strobe(0, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", -1, exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
